// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one simple-dual-port, byte-strobed block RAM between
// two requesters. Round-robin arbitration in IDLE, one-cycle writes and
// incrementing read bursts; one transaction in flight at a time.
module bram_arbiter #(
  parameter int SIZE = 1024,
  parameter int COLS = 4,
  parameter int LW   = 2,
  parameter int AW   = $clog2(SIZE),
  parameter int DW   = COLS * 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_we,
  input  logic [2*AW-1:0]   m_addr,
  input  logic [2*LW-1:0]   m_len,
  input  logic [2*COLS-1:0] m_wstrb,
  input  logic [2*DW-1:0]   m_wdata,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [1:0]        m_rlast,
  output logic [DW-1:0]     m_rdata,
  output logic [COLS-1:0]   b_wstrb,
  output logic [AW-1:0]     b_waddr,
  output logic [DW-1:0]     b_wdata,
  output logic [AW-1:0]     b_raddr,
  input  logic [DW-1:0]     b_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t          state_reg;
  logic            ptr_reg;     // master that wins when both request
  logic            owner_reg;   // master being serviced
  logic [AW-1:0]   addr_reg;    // next read address of the burst
  logic [LW-1:0]   cnt_reg;     // beats still to issue after the current one

  // Per-master views of the packed command buses
  logic          we_m    [2];
  logic [AW-1:0] addr_m  [2];
  logic [LW-1:0] len_m   [2];
  logic [COLS-1:0] wstrb_m [2];
  logic [DW-1:0] wdata_m [2];

  logic          grant_valid;
  logic          winner;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign we_m[gi]    = m_we[gi];
      assign addr_m[gi]  = m_addr[gi*AW +: AW];
      assign len_m[gi]   = m_len[gi*LW +: LW];
      assign wstrb_m[gi] = m_wstrb[gi*COLS +: COLS];
      assign wdata_m[gi] = m_wdata[gi*DW +: DW];
    end
  endgenerate

  // Read data is not re-registered: the RAM output is already one cycle
  // behind the address, which lines up with m_rvalid.
  assign m_rdata = b_rdata;

  // Round-robin pick: a lone requester always wins, a tie goes to ptr_reg
  always_comb begin
    grant_valid = |m_req;
    winner      = ptr_reg;
    if (m_req == 2'b01) begin
      winner = 1'b0;
    end else if (m_req == 2'b10) begin
      winner = 1'b1;
    end
  end

  // Control FSM: arbitration, command latching, RAM port drive and grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      m_gnt     <= '0;
      b_wstrb   <= '0;
      b_waddr   <= '0;
      b_wdata   <= '0;
      b_raddr   <= '0;
    end else begin
      // Pulses default low; only the cycle that needs them raises them
      m_gnt   <= '0;
      b_wstrb <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            owner_reg <= winner;
            ptr_reg   <= ~winner;
            m_gnt     <= onehot(winner);
            if (we_m[winner]) begin
              // The write itself happens in the single WR cycle
              state_reg <= WR;
              b_wstrb   <= wstrb_m[winner];
              b_waddr   <= addr_m[winner];
              b_wdata   <= wdata_m[winner];
            end else begin
              // First beat address goes out in the first RD cycle
              state_reg <= RD;
              b_raddr   <= addr_m[winner];
              addr_reg  <= addr_m[winner] + 1'b1;
              cnt_reg   <= len_m[winner];
            end
          end
        end
        WR: begin
          state_reg <= IDLE;
        end
        RD: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            // Address wraps naturally at 2^AW
            b_raddr  <= addr_reg;
            addr_reg <= addr_reg + 1'b1;
            cnt_reg  <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Read return: flag each beat one cycle after its address was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rvalid <= '0;
      m_rlast  <= '0;
    end else begin
      m_rvalid <= '0;
      m_rlast  <= '0;
      if (state_reg == RD) begin
        m_rvalid <= onehot(owner_reg);
        if (cnt_reg == '0) begin
          m_rlast <= onehot(owner_reg);
        end
      end
    end
  end

  // Structural invariants of the handshake outputs
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(m_gnt));
  a_rvalid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(m_rvalid));
  a_rlast_has_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (m_rlast & ~m_rvalid) == 2'b00);

endmodule
